board_ram_arbiter: RTL and testbench

//  Owns the 40x30 one-bit snake board RAM and shares its single port between the VGA scan-out
//  (read-only, latency-critical) and the game engine (read/write, valid/ready).

---
 rtl/snake_pkg.sv | 34 +++
 rtl/board_ram.sv | 26 ++
 rtl/board_ram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake board RAM arbiter.
// Holds the board geometry, RAM address width, arbiter FSM encoding and the
// cell-coordinate helpers used by the arbiter.
// No ports (package).
package snake_pkg;

  localparam logic [5:0]  GRID_W   = 6'd40;
  localparam logic [5:0]  GRID_H   = 6'd30;
  localparam int unsigned CELL_W   = 6;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned CELLS    = 1200;
  localparam logic [ADDR_W-1:0] LAST_CELL = 11'd1199;
  localparam logic [3:0]  MAX_WAIT = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StVgaRd,
    StGameRd,
    StGameWr,
    StClr
  } arb_state_e;

  function automatic logic cell_in_range(logic [CELL_W-1:0] x, logic [CELL_W-1:0] y);
    return (x < GRID_W) && (y < GRID_H);
  endfunction

  // y*40 + x as shift-add; only meaningful when the cell is in range.
  function automatic logic [ADDR_W-1:0] cell_addr(logic [CELL_W-1:0] x, logic [CELL_W-1:0] y);
    logic [11:0] a;
    a = ({6'd0, y} << 5) + ({6'd0, y} << 3) + {6'd0, x};
    return a[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/board_ram.sv
// 1200x1 synchronous single-port board RAM.
// Write takes effect at the clock edge; read data appears one cycle after the
// address is presented.
// Ports: clk_i clock, addr_i cell address, we_i write enable, wdata_i write
// data, rdata_o registered read data.
module board_ram import snake_pkg::*; (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              wdata_i,
  output logic              rdata_o
);

  logic mem_q [CELLS];
  logic rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/board_ram_arbiter.sv
// Snake board RAM arbiter: shares the single-port board RAM between VGA
// scan-out (top priority, read-only), the game engine (valid/ready read/write)
// and a sequenced full-board clear.
// Ports: clk_25M/rst_n clock and async active-low reset; pixel_x/pixel_y VGA
// cell, pixel_data registered cell value; req_* game request channel with
// req_ready handshake; rsp_valid/rsp_rdata one-cycle read response;
// clear_start clear pulse, busy clear in progress.
// Optional: BOARD_ARB_STARVE_GUARD_EN grants the game an IDLE slot ahead of a
// stale VGA fetch once it has waited MAX_WAIT cycles.
module board_ram_arbiter import snake_pkg::*; (
  input  logic              clk_25M,
  input  logic              rst_n,
  input  logic [CELL_W-1:0] pixel_x,
  input  logic [CELL_W-1:0] pixel_y,
  output logic              pixel_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [CELL_W-1:0] req_x,
  input  logic [CELL_W-1:0] req_y,
  input  logic              req_wdata,
  output logic              rsp_valid,
  output logic              rsp_rdata,
  input  logic              clear_start,
  output logic              busy
);

  arb_state_e state_q, state_d;

  logic                stale_q, stale_d;
  logic [2*CELL_W-1:0] last_pix_q, last_pix_d;   // {y,x} of the last VGA fetch
  logic                vga_pend_q, rsp_pend_q, pend_oor_q;
  logic                req_we_q, req_wdata_q;
  logic [CELL_W-1:0]   req_x_q, req_y_q;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                busy_q, busy_d;
  logic                pixel_data_q, rsp_valid_q, rsp_rdata_q;

  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we, ram_wdata, ram_rdata;

  logic                pix_in, game_in, last_in, vga_stale, game_first, accept, wr_hit;
  logic [ADDR_W-1:0]   pix_addr, game_addr, last_addr;

  assign pix_in    = cell_in_range(pixel_x, pixel_y);
  assign pix_addr  = cell_addr(pixel_x, pixel_y);
  assign game_in   = cell_in_range(req_x_q, req_y_q);
  assign game_addr = cell_addr(req_x_q, req_y_q);
  assign last_in   = cell_in_range(last_pix_q[CELL_W-1:0], last_pix_q[2*CELL_W-1:CELL_W]);
  assign last_addr = cell_addr(last_pix_q[CELL_W-1:0], last_pix_q[2*CELL_W-1:CELL_W]);

  assign vga_stale = stale_q || ({pixel_y, pixel_x} != last_pix_q);

`ifdef BOARD_ARB_STARVE_GUARD_EN
  logic [3:0] wait_q, wait_d;

  assign game_first = (wait_q == MAX_WAIT) && req_valid && !busy_q;

  always_comb begin
    wait_d = wait_q;
    if (accept) begin
      wait_d = '0;
    end else if (req_valid && !req_ready && (wait_q != MAX_WAIT)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign game_first = 1'b0;
`endif

  assign req_ready = (state_q == StIdle) && !busy_q && (!vga_stale || game_first);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = StIdle;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (vga_stale && !game_first) begin
          state_d = StVgaRd;
        end else if (busy_q) begin
          state_d = StClr;
        end else if (accept) begin
          state_d = req_we ? StGameWr : StGameRd;
        end
      end
      StVgaRd:  ram_addr = pix_in ? pix_addr : '0;
      StGameRd: ram_addr = game_in ? game_addr : '0;
      StGameWr: begin
        ram_addr  = game_in ? game_addr : '0;
        ram_we    = game_in;      // out-of-range writes are accepted but dropped
        ram_wdata = req_wdata_q;
      end
      StClr: begin
        ram_addr = clr_cnt_q;
        ram_we   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // A write landing on the displayed cell forces a refetch.
  assign wr_hit = ram_we && last_in && (ram_addr == last_addr);

  always_comb begin
    stale_d    = stale_q;
    last_pix_d = last_pix_q;
    if (state_q == StVgaRd) begin
      stale_d    = 1'b0;
      last_pix_d = {pixel_y, pixel_x};
    end
    if (wr_hit) begin
      stale_d = 1'b1;
    end

    busy_d    = busy_q;
    clr_cnt_d = clr_cnt_q;
    if (clear_start && !busy_q) begin
      busy_d = 1'b1;
    end
    if (state_q == StClr) begin
      if (clr_cnt_q == LAST_CELL) begin
        clr_cnt_d = '0;
        busy_d    = 1'b0;
      end else begin
        clr_cnt_d = clr_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      stale_q      <= 1'b1;
      last_pix_q   <= '0;
      vga_pend_q   <= 1'b0;
      rsp_pend_q   <= 1'b0;
      pend_oor_q   <= 1'b0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= 1'b0;
      req_x_q      <= '0;
      req_y_q      <= '0;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b0;
      pixel_data_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stale_q    <= stale_d;
      last_pix_q <= last_pix_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      vga_pend_q <= (state_q == StVgaRd);
      rsp_pend_q <= (state_q == StGameRd);
      if (state_q == StVgaRd) begin
        pend_oor_q <= !pix_in;
      end else if (state_q == StGameRd) begin
        pend_oor_q <= !game_in;
      end
      if (accept) begin
        req_we_q    <= req_we;
        req_wdata_q <= req_wdata;
        req_x_q     <= req_x;
        req_y_q     <= req_y;
      end
      // RAM data is valid the cycle after the read was issued.
      if (vga_pend_q) begin
        pixel_data_q <= pend_oor_q ? 1'b0 : ram_rdata;
      end
      rsp_valid_q <= rsp_pend_q;
      if (rsp_pend_q) begin
        rsp_rdata_q <= pend_oor_q ? 1'b0 : ram_rdata;
      end
    end
  end

  board_ram u_board_ram (
    .clk_i   (clk_25M),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign pixel_data = pixel_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: directed scenarios plus random
// game traffic, checked every cycle against a cell-array model of the board.
module tb_board_ram_arbiter;

  logic       clk_25M = 1'b0;
  logic       rst_n;
  logic [5:0] pixel_x, pixel_y, req_x, req_y;
  logic       pixel_data, req_valid, req_ready, req_we, req_wdata;
  logic       rsp_valid, rsp_rdata, clear_start, busy;

  always #20 clk_25M = ~clk_25M;

  board_ram_arbiter dut (
    .clk_25M     (clk_25M),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_data  (pixel_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk_25M) cyc <= cyc + 1;

  // Board model and expected read responses (due cycle, data).
  bit model_mem [1200];
  typedef struct { int due; bit data; } rsp_t;
  rsp_t        rspq [$];
  int          pix_age = 0;
  logic [11:0] pix_prev = '0;
  bit          clr_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(logic [5:0] x, logic [5:0] y);
    return (x < 6'd40) && (y < 6'd30);
  endfunction

  function automatic int lin(logic [5:0] x, logic [5:0] y);
    return int'(y) * 40 + int'(x);
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk_25M) begin
    bit exp_rv, exp_rd, exp_pix;
    if (mon_en) begin
      exp_rv = 1'b0;
      exp_rd = 1'b0;
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        exp_rv = 1'b1;
        exp_rd = rspq[0].data;
        void'(rspq.pop_front());
      end
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) check("rsp_rdata", rsp_rdata, exp_rd);

      if (busy) begin
        clr_seen = 1'b1;
        check("ready_in_clear", req_ready, 0);
      end else if (clr_seen) begin
        clr_seen = 1'b0;
        foreach (model_mem[i]) model_mem[i] = 1'b0;
      end

      if ({pixel_y, pixel_x} != pix_prev || busy) pix_age = 0;
      else if (pix_age < 100) pix_age++;
      pix_prev = {pixel_y, pixel_x};
      exp_pix = in_rng(pixel_x, pixel_y) ? model_mem[lin(pixel_x, pixel_y)] : 1'b0;
      if (pix_age >= 7) check("pixel_data", pixel_data, exp_pix);

      if (req_valid && req_ready) begin
        if (req_we) begin
          if (in_rng(req_x, req_y)) begin
            model_mem[lin(req_x, req_y)] = req_wdata;
            if ({req_y, req_x} == {pixel_y, pixel_x}) pix_age = 0;
          end
        end else begin
          rspq.push_back('{cyc + 3, in_rng(req_x, req_y) ? model_mem[lin(req_x, req_y)] : 1'b0});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_25M);
    #1;
  endtask

  // Issue one request; returns the cycle count seen at the accepting negedge.
  task automatic do_req(input bit we, input logic [5:0] x, input logic [5:0] y, input bit wd,
                        output int acc);
    int t;
    t = 0;
    acc = -1;
    req_valid = 1'b1; req_we = we; req_x = x; req_y = y; req_wdata = wd;
    while (acc < 0) begin
      @(negedge clk_25M);
      if (req_ready) acc = cyc;
      else if (++t > 300) begin
        checks++; errors++;
        $display("FAIL req_timeout: got no accept expected accept for (%0d,%0d)", x, y);
        acc = cyc;
      end
    end
    @(posedge clk_25M); #1;
    req_valid = 1'b0;
  endtask

  task automatic read_expect(input logic [5:0] x, input logic [5:0] y, input bit exp,
                             input string name);
    int a;
    do_req(1'b0, x, y, 1'b0, a);
    @(negedge clk_25M);
    @(negedge clk_25M);
    check({name, "_early"}, rsp_valid, 0);
    @(negedge clk_25M);
    check({name, "_valid"}, rsp_valid, 1);
    check({name, "_data"}, rsp_rdata, exp);
    @(posedge clk_25M); #1;
  endtask

  task automatic run_clear(output int n);
    n = 0;
    clear_start = 1'b1;
    @(posedge clk_25M); #1;
    clear_start = 1'b0;
    while (busy && n < 4000) begin
      @(posedge clk_25M); #1;
      n++;
    end
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, n, i;
    bit seen, acc_ok;
    rst_n = 1'b0; pixel_x = '0; pixel_y = '0; req_valid = 1'b0; req_we = 1'b0;
    req_x = '0; req_y = '0; req_wdata = 1'b0; clear_start = 1'b0;
    step(3);
    @(negedge clk_25M);
    check("rst_pixel_data", pixel_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk_25M); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Known board contents.
    run_clear(n);
    check("init_clear_len_ok", (n >= 1200 && n <= 3000), 1);
    step(8);

    // 1: pixel latency and value.
    do_req(1'b1, 6'd5, 6'd3, 1'b1, a);
    step(8);
    pixel_x = 6'd5; pixel_y = 6'd3;
    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    check("t1_pixel_5_3", pixel_data, 1);
    @(posedge clk_25M); #1;
    pixel_x = 6'd6;
    repeat (3) @(posedge clk_25M);
    @(negedge clk_25M);
    check("t1_pixel_6_3", pixel_data, 0);
    @(posedge clk_25M); #1;

    // 2: write then read.
    do_req(1'b1, 6'd7, 6'd2, 1'b1, a);
    read_expect(6'd7, 6'd2, 1'b1, "t2_rd_7_2");

    // 3: write under the displayed cell.
    pixel_x = 6'd39; pixel_y = 6'd29;
    step(8);
    do_req(1'b1, 6'd39, 6'd29, 1'b1, a);
    @(negedge clk_25M);
    check("t3_pixel_before", pixel_data, 0);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk_25M);
      seen = (pixel_data === 1'b1);
    end
    check("t3_pixel_updated", seen, 1);
    @(posedge clk_25M); #1;

    // 4: out-of-range request.
    do_req(1'b1, 6'd40, 6'd0, 1'b1, a);
    read_expect(6'd40, 6'd0, 1'b0, "t4_rd_40_0");
    read_expect(6'd0, 6'd1, 1'b0, "t4_rd_0_1");
    read_expect(6'd63, 6'd63, 1'b0, "t4_rd_63_63");

    // 5: fill the board, clear with a request held pending.
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        do_req(1'b1, 6'(x), 6'(y), 1'b1, a);
    read_expect(6'd20, 6'd15, 1'b1, "t5_rd_full");
    req_valid = 1'b1; req_we = 1'b0; req_x = 6'd2; req_y = 6'd2;
    run_clear(n);
    req_valid = 1'b0;
    check("t5_clear_len_ok", (n >= 1200 && n <= 3000), 1);
    read_expect(6'd0, 6'd0, 1'b0, "t5_rd_0_0");
    read_expect(6'd39, 6'd29, 1'b0, "t5_rd_39_29");
    read_expect(6'd2, 6'd2, 1'b0, "t5_rd_2_2");

    // Clear pulse coinciding with an accepted write: write lands, then clear.
    step(10);
    req_valid = 1'b1; req_we = 1'b1; req_x = 6'd10; req_y = 6'd10; req_wdata = 1'b1;
    clear_start = 1'b1;
    @(negedge clk_25M);
    check("clr_same_ready", req_ready, 1);
    @(posedge clk_25M); #1;
    req_valid = 1'b0; clear_start = 1'b0;
    check("clr_same_busy", busy, 1);
    n = 0;
    while (busy && n < 4000) begin
      step(1);
      n++;
    end
    check("clr_same_done", busy, 0);
    read_expect(6'd10, 6'd10, 1'b0, "clr_same_rd");

    // 6: VGA address moving every cycle with a request held.
    req_valid = 1'b1; req_we = 1'b0; req_x = 6'd1; req_y = 6'd1;
    acc_ok = 1'b0;
    for (i = 0; i < 40 && !acc_ok; i++) begin
      pixel_x = pixel_x ^ 6'd1;
      @(negedge clk_25M);
      if (req_ready) acc_ok = 1'b1;
      @(posedge clk_25M); #1;
    end
    req_valid = 1'b0;
`ifdef BOARD_ARB_STARVE_GUARD_EN
    check("t6_guard_accept", acc_ok, 1);
    check("t6_guard_wait_ok", (i <= 12), 1);
`else
    check("t6_strict_no_accept", acc_ok, 0);
    read_expect(6'd1, 6'd1, 1'b0, "t6_stable_rd");
`endif
    step(10);

    // Random traffic.
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        pixel_x = 6'($urandom_range(0, 41));
        pixel_y = 6'($urandom_range(0, 31));
      end
      do_req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 41)), 6'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), a);
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, 4));
    end
    step(12);
    check("rsp_drain", rspq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
